fetch_queue: RTL and testbench

- Instruction buffer between the second fetch stage and decode.
- Accepts up to FETCH_WIDTH fetched instructions per cycle, in arbitrary valid-slot patterns, and compacts them in slot order into a circular queue.
- Presents up to DECODE_WIDTH oldest entries to decode each cycle.
- Absorbs rate mismatch and decode stalls, back-pressures fetch, and is cleared by a pipeline flush.

---
 rtl/fetch_queue_pkg.sv | 26 ++
 rtl/fetch_queue_compact.sv | 34 +++
 rtl/fetch_queue.sv | 135 +++++++++++++
 tb/tb_fetch_queue.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and sizing for the fetch queue between fetch stage 2 and decode.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_queue_pkg;

  // Queue geometry. DEPTH must be a power of two and at least twice FETCH_WIDTH,
  // so a full fetch group can always land while o_ready is high.
  localparam int FETCH_WIDTH       = 4;
  localparam int DECODE_WIDTH      = 2;
  localparam int FETCH_QUEUE_DEPTH = 16;
  localparam int PADDR_WIDTH       = 32;

  // One fetch/decode slot: valid flag, PC and raw instruction word.
  typedef struct packed {
    logic                   valid;
    logic [PADDR_WIDTH-1:0] pc;
    logic [31:0]            instr;
  } fetched_instr_t;

  // Stored queue entry; validity is implied by head/count, so it is not kept.
  typedef struct packed {
    logic [PADDR_WIDTH-1:0] pc;
    logic [31:0]            instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_compact.sv
// Slot compaction: prefix popcount of fetch valid bits -> per-slot write offset and total.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the valid mask.
//
// Ports:
//   i_vld     per-slot valid bits of the incoming fetch group
//   o_offset  number of valid slots strictly below slot k (write offset from tail)
//   o_n_in    total number of valid slots
module fetch_compact
  import fetch_queue_pkg::*;
#(
  parameter int FW = FETCH_WIDTH,
  parameter int OW = $clog2(FETCH_WIDTH + 1)
) (
  input  logic [FW-1:0]          i_vld,
  output logic [FW-1:0][OW-1:0]  o_offset,
  output logic [OW-1:0]          o_n_in
);

  logic [OW-1:0] acc;

  // Running sum: slot k's offset is the count of valid slots before it, which
  // packs valid slots contiguously in ascending slot order.
  always_comb begin
    acc      = '0;
    o_offset = '0;
    for (int k = 0; k < FW; k++) begin
      o_offset[k] = acc;
      acc         = acc + OW'(i_vld[k]);
    end
    o_n_in = acc;
  end

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer: compacts up to FETCH_WIDTH fetched slots per cycle, presents DECODE_WIDTH oldest.
// Latency: an entry written in cycle N appears on o_instrs in cycle N+1 (no bypass).
// Backpressure: o_ready low when fewer than FETCH_WIDTH entries free; whole group is then dropped and upstream holds.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_instrs        fetch group, any valid-slot pattern
//   o_ready         a full fetch group can be accepted this cycle
//   i_flush         synchronous clear of all contents (wins over enqueue/dequeue)
//   o_instrs        head window, slot 0 oldest
//   i_deq_count     entries decode consumes this cycle (clamped to occupancy)
//   o_count         current occupancy
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int FW    = FETCH_WIDTH,
  parameter int DW    = DECODE_WIDTH,
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int DQ_W  = $clog2(DW + 1),
  localparam int OW    = $clog2(FW + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  fetched_instr_t [0:FW-1]     i_instrs,
  output logic                        o_ready,
  input  logic                        i_flush,
  output fetched_instr_t [0:DW-1]     o_instrs,
  input  logic [DQ_W-1:0]             i_deq_count,
  output logic [CNT_W-1:0]            o_count
);

  // Storage carries no reset; contents are only observed through head/count.
  fq_entry_t          mem [DEPTH];

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic [FW-1:0]          slot_vld;
  logic [FW-1:0][OW-1:0]  slot_off;
  logic [OW-1:0]          n_in;
  logic                   enq_en;
  logic [CNT_W-1:0]       deq;
  logic [CNT_W-1:0]       n_in_eff;

  // ---------------------------------------------------------------------------
  // Compaction of the incoming group
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_vld = '0;
    for (int k = 0; k < FW; k++) begin
      slot_vld[k] = i_instrs[k].valid;
    end
  end

  fetch_compact #(
    .FW (FW),
    .OW (OW)
  ) u_compact (
    .i_vld    (slot_vld),
    .o_offset (slot_off),
    .o_n_in   (n_in)
  );

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  // Based on the pre-cycle count only: a same-cycle dequeue does not open the
  // gate, which keeps o_ready off the decode -> fetch combinational path.
  assign o_ready = (count <= CNT_W'(DEPTH - FW));

  // Flush discards the group, so nothing is written in a flush cycle.
  assign enq_en   = o_ready && (|slot_vld) && !i_flush;
  assign n_in_eff = enq_en ? CNT_W'(n_in) : '0;

  // Dequeue clamped to both occupancy and window width; over-request is safe.
  always_comb begin
    deq = CNT_W'(i_deq_count);
    if (deq > count) begin
      deq = count;
    end
    if (deq > CNT_W'(DW)) begin
      deq = CNT_W'(DW);
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer and occupancy state
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // Pointer width equals log2(DEPTH), so truncation gives the wrap.
      head  <= head + PTR_W'(deq);
      tail  <= tail + PTR_W'(n_in_eff);
      count <= count - deq + n_in_eff;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage write: valid slots land at tail + prefix offset (mod DEPTH)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (enq_en) begin
      for (int k = 0; k < FW; k++) begin
        if (slot_vld[k]) begin
          mem[tail + PTR_W'(slot_off[k])] <= '{pc: i_instrs[k].pc, instr: i_instrs[k].instr};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Head window to decode; purely a function of registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < DW; k++) begin
      o_instrs[k].valid = (count > CNT_W'(k));
      o_instrs[k].pc    = mem[head + PTR_W'(k)].pc;
      o_instrs[k].instr = mem[head + PTR_W'(k)].instr;
    end
  end

  assign o_count = count;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int FW    = FETCH_WIDTH;
  localparam int DW    = DECODE_WIDTH;
  localparam int DEPTH = FETCH_QUEUE_DEPTH;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DQ_W  = $clog2(DW + 1);

  logic                     i_clk = 1'b0;
  logic                     i_rst_n;
  fetched_instr_t [0:FW-1]  instrs;
  logic                     o_ready;
  logic                     i_flush;
  fetched_instr_t [0:DW-1]  o_instrs;
  logic [DQ_W-1:0]          i_deq_count;
  logic [CNT_W-1:0]         o_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: a plain FIFO of the accepted entries, oldest at index 0.
  fetched_instr_t mq[$];

  fetch_queue dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_instrs    (instrs),
    .o_ready     (o_ready),
    .i_flush     (i_flush),
    .o_instrs    (o_instrs),
    .i_deq_count (i_deq_count),
    .o_count     (o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every observable output against the reference queue.
  task automatic check(input string tag);
    chk({tag, ".count"}, 64'(o_count), 64'(mq.size()));
    chk({tag, ".ready"}, 64'(o_ready), 64'(mq.size() <= DEPTH - FW));
    for (int k = 0; k < DW; k++) begin
      chk({tag, ".valid"}, 64'(o_instrs[k].valid), 64'(mq.size() > k));
      if (mq.size() > k) begin
        chk({tag, ".pc"},    64'(o_instrs[k].pc),    64'(mq[k].pc));
        chk({tag, ".instr"}, 64'(o_instrs[k].instr), 64'(mq[k].instr));
      end
    end
  endtask

  task automatic set_grp(input logic [FW-1:0] m, input logic [31:0] base);
    for (int k = 0; k < FW; k++) begin
      instrs[k].valid = m[k];
      instrs[k].pc    = PADDR_WIDTH'(base + 32'(4 * k));
      instrs[k].instr = $urandom();
    end
  endtask

  // One clock: apply inputs, advance the reference, sample #1 after the edge.
  task automatic step(input int dq, input bit fl, input string tag);
    int sz;
    int d;
    bit rdy;
    i_deq_count = DQ_W'(dq);
    i_flush     = fl;
    if (fl) begin
      mq.delete();
    end else begin
      sz  = mq.size();
      rdy = (sz <= DEPTH - FW);
      d   = dq;
      if (d > sz) d = sz;
      if (d > DW) d = DW;
      repeat (d) void'(mq.pop_front());
      if (rdy) begin
        for (int k = 0; k < FW; k++) begin
          if (instrs[k].valid) mq.push_back(instrs[k]);
        end
      end
    end
    @(posedge i_clk);
    #1;
    check(tag);
    set_grp('0, 32'h0);
    i_deq_count = '0;
    i_flush     = 1'b0;
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_flush     = 1'b0;
    i_deq_count = '0;
    set_grp('0, 32'h0);
    repeat (2) @(posedge i_clk);
    #1;
    check("reset");
    chk("reset.ready_const", 64'(o_ready), 64'd1);
    i_rst_n = 1'b1;

    // Compaction of a sparse group, in slot order.
    set_grp(4'b1011, 32'h100);
    step(0, 0, "compact");
    chk("compact.cnt3", 64'(o_count), 64'd3);
    chk("compact.pc0", 64'(o_instrs[0].pc), 64'h100);
    chk("compact.pc1", 64'(o_instrs[1].pc), 64'h104);
    step(2, 0, "compact_deq");
    chk("compact.head", 64'(o_instrs[0].pc), 64'h10C);
    step(3, 0, "drain");

    // Fill to full and back-pressure.
    for (int i = 0; i < 4; i++) begin
      set_grp(4'b1111, 32'h1000 + 32'(16 * i));
      step(0, 0, "fill");
    end
    chk("fill.full", 64'(o_count), 64'd16);
    chk("fill.notready", 64'(o_ready), 64'd0);
    set_grp(4'b1111, 32'h2000);
    step(0, 0, "fill_blocked");
    step(2, 0, "fill_deq14");
    chk("fill.r14", 64'(o_ready), 64'd0);
    step(2, 0, "fill_deq12");
    chk("fill.r12", 64'(o_ready), 64'd1);

    // Simultaneous enqueue/dequeue and over-request.
    step(0, 1, "flush0");
    set_grp(4'b1111, 32'h3000);
    step(0, 0, "sim_a");
    set_grp(4'b0001, 32'h3010);
    step(0, 0, "sim_b");
    set_grp(4'b1101, 32'h3020);
    step(2, 0, "sim_c");
    chk("sim.cnt6", 64'(o_count), 64'd6);
    step(2, 0, "sim_d");
    step(2, 0, "sim_e");
    step(1, 0, "sim_f");
    step(2, 0, "overreq");
    chk("overreq.cnt0", 64'(o_count), 64'd0);
    step(3, 0, "empty_deq");

    // Wrap: move head/tail to entry 14 then straddle the end of storage.
    step(0, 1, "flush1");
    for (int i = 0; i < 7; i++) begin
      set_grp(4'b0011, 32'h4000 + 32'(16 * i));
      step(2, 0, "wrap_adv");
    end
    step(2, 0, "wrap_zero");
    set_grp(4'b1111, 32'hA000);
    step(0, 0, "wrap_enq");
    step(2, 0, "wrap_deq1");
    step(2, 0, "wrap_deq2");

    // Flush beats concurrent enqueue and dequeue.
    set_grp(4'b1111, 32'h5000);
    step(0, 0, "fl_a");
    set_grp(4'b1111, 32'h5010);
    step(0, 0, "fl_b");
    set_grp(4'b0001, 32'h5020);
    step(0, 0, "fl_c");
    chk("flush.cnt9", 64'(o_count), 64'd9);
    set_grp(4'b1111, 32'h5030);
    step(2, 1, "flush");
    set_grp(4'b0110, 32'h5040);
    step(0, 0, "post_flush");

    // Asynchronous reset mid-run at occupancy 7.
    step(0, 1, "flush2");
    set_grp(4'b1111, 32'h6000);
    step(0, 0, "rst_a");
    set_grp(4'b0111, 32'h6010);
    step(0, 0, "rst_b");
    chk("rst.cnt7", 64'(o_count), 64'd7);
    i_rst_n = 1'b0;
    #1;
    mq.delete();
    check("rst_async");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    set_grp(4'b1111, 32'h7000);
    step(0, 0, "rst_resume");
    step(2, 0, "rst_resume_deq");

    // Randomised traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      set_grp(FW'($urandom()), $urandom());
      step(int'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
